// File: rtl/ram_pkg.sv
// Shared types and sizes for the RAM8 bank and its parents.
// Build option: RAM8_BYPASS_EN selects write-through reads.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int RAM8_WORDS  = 8;
  localparam int RAM8_ADDR_W = 3;
  localparam int RAM8_WIDTH  = 16;

  localparam logic [RAM8_ADDR_W-1:0] RAM8_LAST =
    RAM8_ADDR_W'(RAM8_WORDS - 1);

  function automatic logic [RAM8_WORDS-1:0] onehot8(
    input logic [RAM8_ADDR_W-1:0] a
  );
    logic [RAM8_WORDS-1:0] v;
    v = '0;
    v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/ram8_word.sv
// One storage word of the RAM8 bank: plain enabled register.
// Contents are defined by the bank's zeroing sweep, not by reset.
module ram8_word #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (en) q <= d;
  end

endmodule

// File: rtl/ram8_bank.sv
// Eight-word register bank with hardware zeroing sweep and registered read.
// Build option: RAM8_BYPASS_EN makes honoured writes appear on out at once.
module ram8_bank
  import ram_pkg::*;
#(
  parameter int WIDTH = RAM8_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [WIDTH-1:0]       in,
  input  logic [RAM8_ADDR_W-1:0] address,
  input  logic                   load,
  input  logic                   clear,
  output logic [WIDTH-1:0]       out,
  output logic                   ready
);

  state_e                 state_q, state_d;
  logic [RAM8_ADDR_W-1:0] cnt_q, cnt_d;
  logic [RAM8_WORDS-1:0]  we;
  logic [WIDTH-1:0]       wdata;
  logic [WIDTH-1:0]       out_d;
  logic [WIDTH-1:0]       word_q [RAM8_WORDS];

  for (genvar i = 0; i < RAM8_WORDS; i++) begin : g_word
    ram8_word #(.WIDTH(WIDTH)) u_word (
      .clk (clk),
      .en  (we[i]),
      .d   (wdata),
      .q   (word_q[i])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we      = '0;
    wdata   = in;
    out_d   = '0;
    unique case (state_q)
      CLEAR: begin
        wdata = '0;
        we    = onehot8(cnt_q);
        if (clear) begin
          cnt_d = '0;
        end else if (cnt_q == RAM8_LAST) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + RAM8_ADDR_W'(1);
        end
      end
      READY: begin
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else begin
          out_d = word_q[address];
          if (load) begin
            we = onehot8(address);
`ifdef RAM8_BYPASS_EN
            out_d = in;
`endif
          end
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      out     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out     <= out_d;
    end
  end

  assign ready = (state_q == READY);

endmodule

// File: tb/tb_ram8_bank.sv
// Directed and random checks of ram8_bank against a word-array model.
// Build option: RAM8_BYPASS_EN switches the expected read-during-write.
module tb_ram8_bank;

`ifdef RAM8_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] in = '0;
  logic [2:0]  address = '0;
  logic        load = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] out;
  logic        ready;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mem [8];
  int          sweep_left;
  logic [15:0] out_m;

  always #5 clk = ~clk;

  ram8_bank #(.WIDTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (in),
    .address (address),
    .load    (load),
    .clear   (clear),
    .out     (out),
    .ready   (ready)
  );

  function automatic void model_restart();
    sweep_left = 8;
    out_m = '0;
    for (int i = 0; i < 8; i++) mem[i] = '0;
  endfunction

  function automatic void model_edge();
    if (sweep_left > 0) begin
      sweep_left = clear ? 8 : sweep_left - 1;
      out_m = '0;
    end else if (clear) begin
      model_restart();
    end else begin
      out_m = (BYP && load) ? in : mem[address];
      if (load) mem[address] = in;
    end
  endfunction

  task automatic check(input string tag);
    logic rdy_m;
    rdy_m = (sweep_left == 0);
    vectors++;
    assert (out === out_m) else begin
      miscompares++;
      $error("FAIL %s out=%h expected=%h", tag, out, out_m);
    end
    assert (ready === rdy_m) else begin
      miscompares++;
      $error("FAIL %s ready=%b expected=%b", tag, ready, rdy_m);
    end
  endtask

  task automatic step(input string tag, input logic ld,
                      input logic clr, input logic [2:0] a,
                      input logic [15:0] d);
    load = ld;
    clear = clr;
    address = a;
    in = d;
    @(posedge clk);
    model_edge();
    #1;
    check(tag);
  endtask

  task automatic rd(input string tag, input logic [2:0] a);
    step(tag, 1'b0, 1'b0, a, 16'hDEAD);
  endtask

  task automatic wr(input string tag, input logic [2:0] a,
                    input logic [15:0] d);
    step(tag, 1'b1, 1'b0, a, d);
  endtask

  initial begin
    model_restart();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state");

    #3 reset_n = 1'b1;
    for (int i = 0; i < 8; i++)
      step("reset_sweep", 1'b1, 1'b0, 3'(i), 16'($urandom));
    for (int i = 0; i < 8; i++) rd("zero_read", 3'(i));
    rd("zero_read7", 3'd7);

    wr("wr3", 3'd3, 16'h1234);
    wr("wr5", 3'd5, 16'hBEEF);
    rd("rd3", 3'd3);
    rd("rd5", 3'd5);
    rd("rd4", 3'd4);

    wr("wr2", 3'd2, 16'h00AA);
    wr("rdw2", 3'd2, 16'h5555);
    rd("rd2_after", 3'd2);

    step("clr_prio", 1'b1, 1'b1, 3'd1, 16'hFFFF);
    for (int i = 0; i < 8; i++)
      step("clr_sweep", 1'b1, 1'b0, 3'd1, 16'hFFFF);
    rd("rd1_cleared", 3'd1);
    rd("rd3_cleared", 3'd3);

    step("clr_a", 1'b0, 1'b1, 3'd0, 16'h0);
    for (int i = 0; i < 4; i++) rd("clr_mid", 3'(i));
    step("clr_b", 1'b0, 1'b1, 3'd0, 16'h0);
    for (int i = 0; i < 8; i++)
      step("clr_restart", 1'b1, 1'b0, 3'(i), 16'h7777);

    wr("wr5b", 3'd5, 16'hBEEF);
    rd("rd5b", 3'd5);
    #2 reset_n = 1'b0;
    model_restart();
    #1;
    check("async_reset");
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold");
    #3 reset_n = 1'b1;
    for (int i = 0; i < 8; i++)
      step("reset_sweep2", 1'b1, 1'b0, 3'(i), 16'hA5A5);
    rd("rd5_zero", 3'd5);

    for (int i = 0; i < 400; i++) begin
      step("random",
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 39) == 0),
           3'($urandom_range(0, 7)),
           16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
